usb_packet_buffer: RTL

- Parametrised successor to the fixed-width glue path between the ULPI USB state machine and application logic.
- TX side: accepts a wide parallel packet of up to TX_BYTES bytes and serialises it byte-by-byte to the USB state machine under a valid/ready handshake.
- RX side: collects incoming bytes into a wide parallel buffer until end-of-packet, then holds it for the consumer until acknowledged.
- Sits between usb_state_machine and the application/glue layer. It replaces the hard-coded 528-bit bus with a length-tagged, flow-controlled interface.

---
 rtl/usb_buf_pkg.sv | 9 +
 rtl/usb_tx_serializer.sv | 48 ++++
 rtl/usb_packet_buffer.sv | 58 +++++
 3 files changed

// File: rtl/usb_buf_pkg.sv
// usb_buf_pkg: shared widths, default sizes and FSM state types for the USB packet buffer
package usb_buf_pkg;
    localparam int BYTE_W = 8;
    localparam int TX_BYTES_DEF = 66;
    localparam int RX_BYTES_DEF = 66;
    localparam int CNT_W_DEF = 7;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_state_t;
    typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;
endpackage

// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: latches a wide packet and streams it out byte 0 first under valid/ready
module usb_tx_serializer import usb_buf_pkg::*; #(
    parameter int TX_BYTES = TX_BYTES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         tx_load,
    input  logic [CNT_W-1:0]             tx_len,
    input  logic [TX_BYTES*BYTE_W-1:0]   tx_data,
    output logic [BYTE_W-1:0]            tx_byte,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_busy,
    output logic                         tx_done
);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(TX_BYTES);
    tx_state_t state, next_state;
    logic [TX_BYTES*BYTE_W-1:0] shift;
    logic [CNT_W-1:0] remaining;
    logic start, accept;
    assign start = state == TX_IDLE && tx_load && tx_len != '0 && tx_len <= LEN_MAX;
    assign accept = state == TX_SEND && tx_ready;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= TX_IDLE;
        else state <= next_state;
    always_comb
        next_state = start ? TX_SEND :
                     accept && remaining == CNT_W'(1) ? TX_DONE :
                     state == TX_DONE ? TX_IDLE : state;
    always_comb begin
        tx_valid = state == TX_SEND;
        tx_busy = state == TX_SEND;
        tx_done = state == TX_DONE;
        tx_byte = tx_valid ? shift[BYTE_W-1:0] : '0;
    end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            shift <= '0;
            remaining <= '0;
        end else if (start) begin
            shift <= tx_data;
            remaining <= tx_len;
        end else if (accept) begin
            shift <= shift >> BYTE_W;
            remaining <= remaining - CNT_W'(1);
        end
endmodule

// File: rtl/usb_packet_buffer.sv
// usb_packet_buffer: TX serialiser plus RX collector between the USB state machine and application
module usb_packet_buffer import usb_buf_pkg::*; #(
    parameter int TX_BYTES = TX_BYTES_DEF,
    parameter int RX_BYTES = RX_BYTES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         tx_load,
    input  logic [CNT_W-1:0]             tx_len,
    input  logic [TX_BYTES*BYTE_W-1:0]   tx_data,
    output logic [BYTE_W-1:0]            tx_byte,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_busy,
    output logic                         tx_done,
    input  logic [BYTE_W-1:0]            rx_byte,
    input  logic                         rx_valid,
    input  logic                         rx_eop,
    output logic [RX_BYTES*BYTE_W-1:0]   rx_data,
    output logic [CNT_W-1:0]             rx_count,
    output logic                         rx_pkt_valid,
    input  logic                         rx_ack,
    output logic                         rx_overflow
);
    localparam logic [CNT_W-1:0] RX_MAX = CNT_W'(RX_BYTES);
    usb_tx_serializer #(.TX_BYTES(TX_BYTES), .CNT_W(CNT_W)) u_tx (
        .clk(clk), .n_rst(n_rst), .tx_load(tx_load), .tx_len(tx_len), .tx_data(tx_data),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .tx_done(tx_done)
    );
    rx_state_t rx_state, rx_next;
    logic collect, rx_store, rx_clear;
    assign collect = rx_state == RX_COLLECT;
    assign rx_store = collect && rx_valid && rx_count < RX_MAX;
    assign rx_clear = rx_state == RX_HOLD && rx_ack;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) rx_state <= RX_COLLECT;
        else rx_state <= rx_next;
    // an eop with nothing stored and no byte alongside would make an empty packet
    always_comb
        rx_next = collect && rx_eop && (rx_valid || rx_count != '0) ? RX_HOLD :
                  rx_clear ? RX_COLLECT : rx_state;
    always_comb rx_pkt_valid = rx_state == RX_HOLD;
    // ack wins over a byte arriving in the same cycle, so overflow is cleared
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst || rx_clear) begin
            rx_data <= '0;
            rx_count <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (rx_store) begin
                rx_data[rx_count*BYTE_W +: BYTE_W] <= rx_byte;
                rx_count <= rx_count + CNT_W'(1);
            end
            if (rx_valid && !rx_store) rx_overflow <= 1'b1;
        end
endmodule
